// File: rtl/mpram_pkg.sv
// Shared definitions for the multi-port single-clock RAM: clear-sequencer
// state encodings and the legal READ_LATENCY values.
package mpram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam int READ_LAT_MIN = 32'sd1;
    localparam int READ_LAT_MAX = 32'sd2;

endpackage

// File: rtl/mpram_clr_fsm.sv
// Hardware clear sequencer: after reset release it walks every address once,
// raising busy and a zero-write strobe until the last word is cleared.
module mpram_clr_fsm
    import mpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32'sd5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    clr_state_e            state_r;
    clr_state_e            state_nxt_s;
    logic                  pend_r;
    logic                  pend_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic                  busy_r;
    logic                  busy_nxt_s;
    logic                  we_r;

    // State register and registered outputs; reset re-arms a clear from address 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            pend_r  <= 1'b1;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            busy_r  <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pend_r  <= pend_nxt_s;
            addr_r  <= addr_nxt_s;
            busy_r  <= busy_nxt_s;
            we_r    <= busy_nxt_s;
        end
    end

    // Next-state logic: one address per cycle while clearing.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        addr_nxt_s  = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (pend_r) begin
                    state_nxt_s = ST_CLEAR;
                    pend_nxt_s  = 1'b0;
                    addr_nxt_s  = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                    pend_nxt_s  = 1'b0;
                    addr_nxt_s  = addr_r;
                end
            end
            ST_CLEAR: begin
                if (addr_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                    addr_nxt_s  = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_nxt_s = ST_CLEAR;
                    addr_nxt_s  = addr_r + ADDR_WIDTH'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pend_nxt_s  = 1'b1;
                addr_nxt_s  = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so busy/strobe leave the register bank.
    always_comb begin
        busy_nxt_s = 1'b0;
        if (state_nxt_s == ST_CLEAR) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    assign busy     = busy_r;
    assign clr_we   = we_r;
    assign clr_addr = addr_r;

endmodule

// File: rtl/mpram_sclk.sv
// Single-clock RAM with one byte-enabled write port and NUM_RD read ports.
// Define MPRAM_HWCLR_EN to build in the post-reset hardware clear sequencer.
module mpram_sclk
    import mpram_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32'sd5,
    parameter int DATA_WIDTH    = 32'sd32,
    parameter int NUM_RD        = 32'sd2,
    parameter int READ_LATENCY  = 32'sd1,
    parameter bit ENABLE_BYPASS = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    input  logic [NUM_RD-1:0]            re,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      wbe,
    input  logic [DATA_WIDTH-1:0]        din,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            rvalid,
    output logic                         busy
);

    localparam int  DEPTH  = 32'sd1 << ADDR_WIDTH;
    localparam int  NBYTES = DATA_WIDTH / 32'sd8;
    localparam bit  LAT2_C = (READ_LATENCY == READ_LAT_MAX);

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NBYTES; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  busy_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic                  wr_en_s;
    logic [NUM_RD-1:0]     rd_en_s;

`ifdef MPRAM_HWCLR_EN
    mpram_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy_s),
        .clr_addr (clr_addr_s),
        .clr_we   (clr_we_s)
    );
`else
    assign busy_s     = 1'b0;
    assign clr_we_s   = 1'b0;
    assign clr_addr_s = {ADDR_WIDTH{1'b0}};
`endif

    assign busy    = busy_s;
    assign wr_en_s = we & ~busy_s;
    assign rd_en_s = re & {NUM_RD{~busy_s}};

    // Memory array: clear strobe has priority; user writes only touch enabled bytes.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s] <= {DATA_WIDTH{1'b0}};
        end else if (wr_en_s) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wbe[k]) begin
                    mem_r[waddr][8*k +: 8] <= din[8*k +: 8];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0] old_s;
        logic [DATA_WIDTH-1:0] word_s;
        logic                  hit_s;
        logic                  v1_r;
        logic [DATA_WIDTH-1:0] d1_r;

        assign ra_s  = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign old_s = mem_r[ra_s];
        assign hit_s = ENABLE_BYPASS & wr_en_s & (waddr == ra_s);

        // Same-cycle write forwarding, or the pre-write word when bypass is off.
        always_comb begin
            word_s = old_s;
            if (hit_s) begin
                word_s = merge_bytes(old_s, din, wbe);
            end else begin
                word_s = old_s;
            end
        end

        // First read stage; data is zeroed whenever the slot carries no result.
        always_ff @(posedge clk) begin
            if (!rst) begin
                v1_r <= 1'b0;
                d1_r <= {DATA_WIDTH{1'b0}};
            end else if (rd_en_s[gi]) begin
                v1_r <= 1'b1;
                d1_r <= word_s;
            end else begin
                v1_r <= 1'b0;
                d1_r <= {DATA_WIDTH{1'b0}};
            end
        end

        if (LAT2_C) begin : g_lat2
            logic                  v2_r;
            logic [DATA_WIDTH-1:0] d2_r;

            // Second output stage for the two-cycle configuration.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v2_r <= 1'b0;
                    d2_r <= {DATA_WIDTH{1'b0}};
                end else begin
                    v2_r <= v1_r;
                    d2_r <= d1_r;
                end
            end

            assign rvalid[gi]                           = v2_r;
            assign dout[gi*DATA_WIDTH +: DATA_WIDTH]    = d2_r;
        end else begin : g_lat1
            assign rvalid[gi]                           = v1_r;
            assign dout[gi*DATA_WIDTH +: DATA_WIDTH]    = d1_r;
        end
    end

endmodule

// File: tb/tb_mpram_sclk.sv
// Directed bench: a default instance (latency 1, bypass on) and a second one
// (latency 2, bypass off) share every input so their answers can be contrasted.
module tb_mpram_sclk;

    logic        clk;
    logic        rst;
    logic [9:0]  raddr;
    logic [1:0]  re;
    logic [4:0]  waddr;
    logic        we;
    logic [3:0]  wbe;
    logic [31:0] din;
    logic [63:0] dout;
    logic [1:0]  rvalid;
    logic        busy;
    logic [63:0] dout2;
    logic [1:0]  rvalid2;
    logic        busy2;

    int n_cmp;
    int n_bad;

`ifdef MPRAM_HWCLR_EN
    localparam int EXP_BUSY = 32;
`else
    localparam int EXP_BUSY = 0;
`endif

    mpram_sclk u_dut (
        .clk    (clk),
        .rst    (rst),
        .raddr  (raddr),
        .re     (re),
        .waddr  (waddr),
        .we     (we),
        .wbe    (wbe),
        .din    (din),
        .dout   (dout),
        .rvalid (rvalid),
        .busy   (busy)
    );

    mpram_sclk #(
        .READ_LATENCY  (2),
        .ENABLE_BYPASS (1'b0)
    ) u_lat2 (
        .clk    (clk),
        .rst    (rst),
        .raddr  (raddr),
        .re     (re),
        .waddr  (waddr),
        .we     (we),
        .wbe    (wbe),
        .din    (din),
        .dout   (dout2),
        .rvalid (rvalid2),
        .busy   (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        waddr = a;
        din   = d;
        wbe   = be;
        we    = 1'b1;
        step();
        we    = 1'b0;
        wbe   = 4'h0;
    endtask

    // Single-port read: latency-1 answer after one edge, latency-2 answer after the next.
    task automatic rd(input string tag, input int p, input logic [4:0] a,
                      input logic [31:0] e1, input logic [31:0] e2);
        raddr            = 10'd0;
        raddr[p*5 +: 5]  = a;
        re               = 2'b00;
        re[p]            = 1'b1;
        step();
        re = 2'b00;
        chk({tag, "_v1"}, 64'(rvalid[p]), 64'd1);
        chk({tag, "_d1"}, 64'(dout[p*32 +: 32]), 64'(e1));
        step();
        chk({tag, "_v2"}, 64'(rvalid2[p]), 64'd1);
        chk({tag, "_d2"}, 64'(dout2[p*32 +: 32]), 64'(e2));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || busy2) && n < 100) begin
            step();
            n++;
        end
        chk("idle", 64'({busy, busy2}), 64'd0);
    endtask

    initial begin
        int cnt;
        int cnt2;
        int bad_rv;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        raddr = 10'd0;
        re    = 2'b00;
        waddr = 5'd0;
        we    = 1'b0;
        wbe   = 4'h0;
        din   = 32'd0;
        repeat (3) step();

        chk("rst_rvalid", 64'({rvalid, rvalid2}), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_dout2", dout2, 64'd0);
        chk("rst_busy", 64'({busy, busy2}), 64'd0);

        // Release reset, count busy cycles and try to disturb the clear.
        rst    = 1'b1;
        cnt    = 0;
        cnt2   = 0;
        bad_rv = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy2) cnt2++;
            if (busy) begin
                cnt++;
                if (rvalid != 2'b00 || rvalid2 != 2'b00) bad_rv++;
                waddr = 5'd5;
                din   = 32'hFFFF_FFFF;
                wbe   = 4'hF;
                we    = 1'b1;
                raddr = 10'd0;
                re    = 2'b11;
            end else begin
                we  = 1'b0;
                wbe = 4'h0;
                re  = 2'b00;
            end
        end
        chk("busy_cycles", 64'(cnt), 64'(EXP_BUSY));
        chk("busy_cycles2", 64'(cnt2), 64'(EXP_BUSY));
        chk("busy_rvalid", 64'(bad_rv), 64'd0);
        wait_idle();
`ifdef MPRAM_HWCLR_EN
        rd("clr0", 0, 5'd0, 32'd0, 32'd0);
        rd("clr5", 1, 5'd5, 32'd0, 32'd0);
        rd("clr31", 0, 5'd31, 32'd0, 32'd0);
`endif

        // Byte enables.
        wr(5'd3, 32'hAABB_CCDD, 4'hF);
        wr(5'd3, 32'h1122_3344, 4'b0101);
        rd("be", 0, 5'd3, 32'hAA22_CC44, 32'hAA22_CC44);
        wr(5'd3, 32'hFFFF_FFFF, 4'h0);
        rd("be0", 1, 5'd3, 32'hAA22_CC44, 32'hAA22_CC44);

        // Two ports, same address, then distinct addresses.
        wr(5'd10, 32'h0123_4567, 4'hF);
        raddr = {5'd3, 5'd3};
        re    = 2'b11;
        step();
        re = 2'b00;
        chk("same_v", 64'(rvalid), 64'd3);
        chk("same_d", dout, {32'hAA22_CC44, 32'hAA22_CC44});
        raddr = {5'd3, 5'd10};
        re    = 2'b11;
        step();
        re = 2'b00;
        chk("diff_d", dout, {32'hAA22_CC44, 32'h0123_4567});
        chk("same_d2", dout2, {32'hAA22_CC44, 32'hAA22_CC44});
        step();
        chk("diff_d2", dout2, {32'hAA22_CC44, 32'h0123_4567});

        // Collisions: forwarded on the default instance, pre-write word on the other.
        wr(5'd7, 32'd0, 4'hF);
        waddr = 5'd7;
        din   = 32'h5A5A_5A5A;
        wbe   = 4'hF;
        we    = 1'b1;
        rd("byp", 0, 5'd7, 32'h5A5A_5A5A, 32'd0);
        we = 1'b0;
        waddr = 5'd7;
        din   = 32'h0000_BEEF;
        wbe   = 4'b0011;
        we    = 1'b1;
        rd("byp_part", 0, 5'd7, 32'h5A5A_BEEF, 32'h5A5A_5A5A);
        we  = 1'b0;
        wbe = 4'h0;
        rd("after_byp", 1, 5'd7, 32'h5A5A_BEEF, 32'h5A5A_BEEF);

        // Single re[1] pulse: valid exactly one cycle, on the right cycle.
        raddr = {5'd10, 5'd0};
        re    = 2'b10;
        step();
        re = 2'b00;
        chk("lat_n1_v1", 64'(rvalid[1]), 64'd1);
        chk("lat_n1_v2", 64'(rvalid2[1]), 64'd0);
        chk("lat_n1_d2", 64'(dout2[63:32]), 64'd0);
        step();
        chk("lat_n2_v1", 64'(rvalid[1]), 64'd0);
        chk("lat_n2_d1", 64'(dout[63:32]), 64'd0);
        chk("lat_n2_v2", 64'(rvalid2[1]), 64'd1);
        chk("lat_n2_d2", 64'(dout2[63:32]), 64'h0123_4567);
        step();
        chk("lat_n3_v2", 64'(rvalid2[1]), 64'd0);
        chk("lat_n3_d2", 64'(dout2[63:32]), 64'd0);

        // Back-to-back reads on port 0 stream one result per cycle.
        raddr = {5'd0, 5'd3};
        re    = 2'b01;
        step();
        chk("b2b_1_d1", 64'(dout[31:0]), 64'hAA22_CC44);
        raddr = {5'd0, 5'd10};
        step();
        chk("b2b_2_d1", 64'(dout[31:0]), 64'h0123_4567);
        chk("b2b_2_d2", 64'(dout2[31:0]), 64'hAA22_CC44);
        raddr = {5'd0, 5'd7};
        step();
        chk("b2b_3_d1", 64'(dout[31:0]), 64'h5A5A_BEEF);
        chk("b2b_3_d2", 64'(dout2[31:0]), 64'h0123_4567);
        re = 2'b00;
        step();
        chk("b2b_4_v1", 64'(rvalid[0]), 64'd0);
        chk("b2b_4_d2", 64'(dout2[31:0]), 64'h5A5A_BEEF);

        // Reset while a read is in flight.
        raddr = {5'd0, 5'd3};
        re    = 2'b01;
        step();
        re = 2'b00;
        chk("rstrd_n1_v1", 64'(rvalid[0]), 64'd1);
        rst = 1'b0;
        step();
        chk("rstrd_n2_v", 64'({rvalid, rvalid2}), 64'd0);
        chk("rstrd_n2_d", 64'(dout2), 64'd0);
        rst = 1'b1;
        step();
        chk("rstrd_n3_v", 64'({rvalid, rvalid2}), 64'd0);
        chk("rstrd_n3_d", dout2 | dout, 64'd0);
        wait_idle();

`ifdef MPRAM_HWCLR_EN
        rd("post_rst", 0, 5'd3, 32'd0, 32'd0);
`else
        rd("post_rst", 0, 5'd3, 32'hAA22_CC44, 32'hAA22_CC44);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
